// File: rtl/motion_bbox_detector.sv
// Frame-difference motion detector: thresholds |Y_cur - Y_prev| into a mask stream
// and publishes the per-frame bounding box and motion-pixel count at frame end.
//
// state  | meaning
// IDLE   | after reset, waiting for the first v_sync rise; nothing accumulated
// ACCUM  | folding in-range motion pixels into box and count
// LATCH  | one cycle: publish accumulators, pulse frame_done, re-initialise
module motion_bbox_detector #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_y_8b,
  input  logic [7:0]  i_prev_y_8b,
  input  logic [7:0]  i_threshold_8b,
  input  logic        i_h_sync,
  input  logic        i_v_sync,
  input  logic        i_data_en,
  output logic        o_motion,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_data_en,
  output logic [9:0]  o_box_x_min,
  output logic [9:0]  o_box_x_max,
  output logic [9:0]  o_box_y_min,
  output logic [9:0]  o_box_y_max,
  output logic [18:0] o_motion_cnt,
  output logic        o_box_valid,
  output logic        o_frame_done
);

  localparam logic [10:0] COL_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] ROW_LIM  = 11'(V_ACTIVE);
  localparam logic [19:0] MIN_CNT  = 20'(MIN_PIXELS);
  localparam logic [9:0]  POS_MAX  = 10'h3FF;
  localparam logic [18:0] CNT_MAX  = 19'h7FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // input-side edge detection, position counters and frame threshold
  logic       vs_in_q, vs_in_d;
  logic       de_in_q, de_in_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic [7:0] thr_q, thr_d;

  // stage 1
  logic [7:0] s1_diff_q, s1_diff_d;
  logic       s1_hs_q, s1_hs_d;
  logic       s1_vs_q, s1_vs_d;
  logic       s1_de_q, s1_de_d;
  logic [9:0] s1_col_q, s1_col_d;
  logic [9:0] s1_row_q, s1_row_d;
  logic       s1_inside_q, s1_inside_d;

  // stage 2
  logic       motion_q, motion_d;
  logic       s2_hs_q, s2_hs_d;
  logic       s2_vs_q, s2_vs_d;
  logic       s2_de_q, s2_de_d;
  logic [9:0] s2_col_q, s2_col_d;
  logic [9:0] s2_row_q, s2_row_d;
  logic       s2_inside_q, s2_inside_d;

  logic              vs_rise_in;
  logic              de_fall_in;
  logic signed [8:0] diff_s;
  logic signed [8:0] diff_abs;

  always_comb begin
    vs_rise_in = i_v_sync & ~vs_in_q;
    de_fall_in = ~i_data_en & de_in_q;

    vs_in_d = i_v_sync;
    de_in_d = i_data_en;

    // v_sync rise wins over a coincident end-of-line
    col_d = col_q;
    row_d = row_q;
    if (vs_rise_in) begin
      col_d = '0;
      row_d = '0;
    end else if (de_fall_in) begin
      col_d = '0;
      if (row_q != POS_MAX) row_d = row_q + 10'd1;
    end else if (i_data_en && (col_q != POS_MAX)) begin
      col_d = col_q + 10'd1;
    end

    thr_d = vs_rise_in ? i_threshold_8b : thr_q;

    diff_s   = $signed({1'b0, i_y_8b}) - $signed({1'b0, i_prev_y_8b});
    diff_abs = diff_s[8] ? -diff_s : diff_s;

    s1_diff_d   = diff_abs[7:0];
    s1_hs_d     = i_h_sync;
    s1_vs_d     = i_v_sync;
    s1_de_d     = i_data_en;
    s1_col_d    = col_q;
    s1_row_d    = row_q;
    s1_inside_d = i_data_en & ({1'b0, col_q} < COL_LIM) & ({1'b0, row_q} < ROW_LIM);

    motion_d    = s1_de_q & (s1_diff_q > thr_q);
    s2_hs_d     = s1_hs_q;
    s2_vs_d     = s1_vs_q;
    s2_de_d     = s1_de_q;
    s2_col_d    = s1_col_q;
    s2_row_d    = s1_row_q;
    s2_inside_d = s1_inside_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_in_q     <= 1'b0;
      de_in_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      thr_q       <= '0;
      s1_diff_q   <= '0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_de_q     <= 1'b0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      s1_inside_q <= 1'b0;
      motion_q    <= 1'b0;
      s2_hs_q     <= 1'b0;
      s2_vs_q     <= 1'b0;
      s2_de_q     <= 1'b0;
      s2_col_q    <= '0;
      s2_row_q    <= '0;
      s2_inside_q <= 1'b0;
    end else begin
      vs_in_q     <= vs_in_d;
      de_in_q     <= de_in_d;
      col_q       <= col_d;
      row_q       <= row_d;
      thr_q       <= thr_d;
      s1_diff_q   <= s1_diff_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_de_q     <= s1_de_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      s1_inside_q <= s1_inside_d;
      motion_q    <= motion_d;
      s2_hs_q     <= s2_hs_d;
      s2_vs_q     <= s2_vs_d;
      s2_de_q     <= s2_de_d;
      s2_col_q    <= s2_col_d;
      s2_row_q    <= s2_row_d;
      s2_inside_q <= s2_inside_d;
    end
  end

  // Frame end is taken from the stage-1/stage-2 v_sync pair so it trails the pixel path
  logic vs_rise_pipe;
  logic acc_hit;
  logic frame_valid;

  assign vs_rise_pipe = s1_vs_q & ~s2_vs_q;
  assign acc_hit      = motion_q & s2_inside_q;

  state_t      state_q;
  logic [9:0]  x_min_q, x_max_q, y_min_q, y_max_q;
  logic [18:0] cnt_q;
  logic [9:0]  box_x_min_q, box_x_max_q, box_y_min_q, box_y_max_q;
  logic [18:0] motion_cnt_q;
  logic        box_valid_q;
  logic        frame_done_q;

  assign frame_valid = ({1'b0, cnt_q} >= MIN_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_min_q      <= POS_MAX;
      x_max_q      <= '0;
      y_min_q      <= POS_MAX;
      y_max_q      <= '0;
      cnt_q        <= '0;
      box_x_min_q  <= '0;
      box_x_max_q  <= '0;
      box_y_min_q  <= '0;
      box_y_max_q  <= '0;
      motion_cnt_q <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (vs_rise_pipe) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (acc_hit) begin
            if (s2_col_q < x_min_q) x_min_q <= s2_col_q;
            if (s2_col_q > x_max_q) x_max_q <= s2_col_q;
            if (s2_row_q < y_min_q) y_min_q <= s2_row_q;
            if (s2_row_q > y_max_q) y_max_q <= s2_row_q;
            if (cnt_q != CNT_MAX)   cnt_q   <= cnt_q + 19'd1;
          end
          if (vs_rise_pipe) state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          // any pixel reaching stage 2 now is dropped, not carried into the next frame
          box_x_min_q  <= frame_valid ? x_min_q : '0;
          box_x_max_q  <= frame_valid ? x_max_q : '0;
          box_y_min_q  <= frame_valid ? y_min_q : '0;
          box_y_max_q  <= frame_valid ? y_max_q : '0;
          motion_cnt_q <= cnt_q;
          box_valid_q  <= frame_valid;
          frame_done_q <= 1'b1;
          x_min_q      <= POS_MAX;
          x_max_q      <= '0;
          y_min_q      <= POS_MAX;
          y_max_q      <= '0;
          cnt_q        <= '0;
          state_q      <= ST_ACCUM;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_motion     = motion_q;
  assign o_h_sync     = s2_hs_q;
  assign o_v_sync     = s2_vs_q;
  assign o_data_en    = s2_de_q;
  assign o_box_x_min  = box_x_min_q;
  assign o_box_x_max  = box_x_max_q;
  assign o_box_y_min  = box_y_min_q;
  assign o_box_y_max  = box_y_max_q;
  assign o_motion_cnt = motion_cnt_q;
  assign o_box_valid  = box_valid_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_motion_bbox_detector.sv
// Scoreboard bench for motion_bbox_detector: a behavioural model predicts the pixel
// stream and per-frame box results, the monitor compares them as the DUT produces them.
module tb_motion_bbox_detector;

  localparam int H = 8;
  localparam int V = 8;
  localparam int MINP = 4;

  localparam int P_BOUND = 0;
  localparam int P_BLOCK = 1;
  localparam int P_FEW   = 2;
  localparam int P_RAND  = 3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_y_8b, i_prev_y_8b, i_threshold_8b;
  logic        i_h_sync, i_v_sync, i_data_en;
  logic        o_motion, o_h_sync, o_v_sync, o_data_en;
  logic [9:0]  o_box_x_min, o_box_x_max, o_box_y_min, o_box_y_max;
  logic [18:0] o_motion_cnt;
  logic        o_box_valid, o_frame_done;

  motion_bbox_detector #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_y_8b(i_y_8b), .i_prev_y_8b(i_prev_y_8b), .i_threshold_8b(i_threshold_8b),
    .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_data_en(i_data_en),
    .o_motion(o_motion), .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_data_en(o_data_en),
    .o_box_x_min(o_box_x_min), .o_box_x_max(o_box_x_max),
    .o_box_y_min(o_box_y_min), .o_box_y_max(o_box_y_max),
    .o_motion_cnt(o_motion_cnt), .o_box_valid(o_box_valid), .o_frame_done(o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int   cyc;
    logic mot, hs, vs, de;
  } pix_t;

  typedef struct {
    int          cyc;
    logic [9:0]  x0, x1, y0, y1;
    logic [18:0] cnt;
    logic        valid;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];

  // behavioural model state
  logic [7:0]  m_thr;
  logic        m_acc, m_vs_prev, m_de_prev;
  int          m_col, m_row;
  int          m_x0, m_x1, m_y0, m_y1, m_cnt;

  task automatic model_init_acc();
    m_x0 = 1023; m_x1 = 0; m_y0 = 1023; m_y1 = 0; m_cnt = 0;
  endtask

  task automatic model_reset();
    m_thr = 0; m_acc = 0; m_vs_prev = 0; m_de_prev = 0;
    m_col = 0; m_row = 0;
    model_init_acc();
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [7:0] y, input logic [7:0] py);
    logic rise_vs, fall_de, mot;
    int   d;
    pix_t p;
    frm_t f;
    @(posedge clk); #1;
    i_data_en = de; i_h_sync = hs; i_v_sync = vs; i_y_8b = y; i_prev_y_8b = py;
    rise_vs = vs & ~m_vs_prev;
    fall_de = ~de & m_de_prev;
    if (rise_vs) m_thr = i_threshold_8b;
    d = int'(y) - int'(py);
    if (d < 0) d = -d;
    mot = de && (d > int'(m_thr));
    p.cyc = cyc; p.mot = mot; p.hs = hs; p.vs = vs; p.de = de;
    pq.push_back(p);
    if (rise_vs) begin
      if (m_acc) begin
        f.cyc   = cyc;
        f.valid = (m_cnt >= MINP);
        f.x0    = f.valid ? 10'(m_x0) : 10'd0;
        f.x1    = f.valid ? 10'(m_x1) : 10'd0;
        f.y0    = f.valid ? 10'(m_y0) : 10'd0;
        f.y1    = f.valid ? 10'(m_y1) : 10'd0;
        f.cnt   = 19'(m_cnt);
        fq.push_back(f);
      end
      m_acc = 1;
      model_init_acc();
    end else if (m_acc && mot && m_col < H && m_row < V) begin
      if (m_col < m_x0) m_x0 = m_col;
      if (m_col > m_x1) m_x1 = m_col;
      if (m_row < m_y0) m_y0 = m_row;
      if (m_row > m_y1) m_y1 = m_row;
      if (m_cnt < 524287) m_cnt++;
    end
    if (rise_vs) begin
      m_col = 0; m_row = 0;
    end else if (fall_de) begin
      m_col = 0;
      if (m_row < 1023) m_row++;
    end else if (de && m_col < 1023) begin
      m_col++;
    end
    m_vs_prev = vs;
    m_de_prev = de;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    i_data_en = 0; i_h_sync = 0; i_v_sync = 0; i_y_8b = 0; i_prev_y_8b = 0;
    #1;
    check_val("rst_outs",
      {o_motion, o_h_sync, o_v_sync, o_data_en, o_box_x_min, o_box_x_max,
       o_box_y_min, o_box_y_max, o_motion_cnt, o_box_valid, o_frame_done}, 128'd0);
    pq.delete();
    fq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic send_vs();
    repeat (4) drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic send_frame(input int pat, input int ncols, input int nrows,
                            input int thr_row, input logic [7:0] thr_new, input int rst_row);
    send_vs();
    for (int r = 0; r < nrows; r++) begin
      if (r == rst_row) do_reset();
      if (r == thr_row) i_threshold_8b = thr_new;
      for (int c = 0; c < ncols; c++) begin
        logic [7:0] y, p;
        y = 8'd100;
        p = 8'd100;
        case (pat)
          P_BOUND: if (r == 0) begin
            case (c)
              0: y = 8'd130;
              1: y = 8'd131;
              2: y = 8'd70;
              3: y = 8'd69;
              default: y = 8'd100;
            endcase
          end
          P_BLOCK: if (c >= 2 && c <= 4 && r >= 3 && r <= 5) y = 8'd150;
          P_FEW:   if ((c == 1 && r == 1) || (c == 5 && r == 2) || (c == 6 && r == 6)) y = 8'd150;
          default: begin
            y = 8'($urandom_range(0, 255));
            p = 8'($urandom_range(0, 255));
          end
        endcase
        drive(1'b1, 1'b0, 1'b0, y, p);
      end
      drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    end
  endtask

  // monitor: outputs sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    pix_t p;
    frm_t f;
    if (rst_n) begin
      while (pq.size() > 0 && pq[0].cyc + 2 <= cyc) begin
        p = pq.pop_front();
        check_val("pix_mot_hs_vs_de", {o_motion, o_h_sync, o_v_sync, o_data_en},
                  {p.mot, p.hs, p.vs, p.de});
      end
      if (fq.size() > 0 && fq[0].cyc + 3 < cyc) begin
        f = fq.pop_front();
        check_val("frame_done_missed", 1'b0, 1'b1);
      end else if (fq.size() > 0 && fq[0].cyc + 3 == cyc) begin
        f = fq.pop_front();
        check_val("frame_done", o_frame_done, 1'b1);
        check_val("box", {o_box_x_min, o_box_x_max, o_box_y_min, o_box_y_max},
                  {f.x0, f.x1, f.y0, f.y1});
        check_val("motion_cnt", o_motion_cnt, f.cnt);
        check_val("box_valid", o_box_valid, f.valid);
      end else if (o_frame_done) begin
        check_val("spurious_done", o_frame_done, 1'b0);
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0;
    i_y_8b = 0; i_prev_y_8b = 0; i_h_sync = 0; i_v_sync = 0; i_data_en = 0;
    i_threshold_8b = 8'd30;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_val("reset_outs",
      {o_motion, o_h_sync, o_v_sync, o_data_en, o_box_x_min, o_box_x_max,
       o_box_y_min, o_box_y_max, o_motion_cnt, o_box_valid, o_frame_done}, 128'd0);
    #1 rst_n = 1'b1;

    send_frame(P_BOUND, H, V, -1, 8'd0, -1);
    i_threshold_8b = 8'd10;
    send_frame(P_BLOCK, H, V, -1, 8'd0, -1);
    send_frame(P_FEW, H, V, -1, 8'd0, -1);
    send_frame(P_BLOCK, H, V, 1, 8'd200, -1);
    send_frame(P_BLOCK, H, V, -1, 8'd0, -1);
    i_threshold_8b = 8'd10;
    send_frame(P_BLOCK, H, V, -1, 8'd0, -1);
    send_frame(P_FEW, H, V, -1, 8'd0, 4);
    send_frame(P_BLOCK, H, V, -1, 8'd0, -1);
    i_threshold_8b = 8'd60;
    send_frame(P_RAND, 10, 9, -1, 8'd0, -1);
    send_vs();
    repeat (8) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    waited = 0;
    while ((pq.size() > 0 || fq.size() > 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (pq.size() > 0 || fq.size() > 0)
      check_val("drain_timeout", 128'(pq.size() + fq.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
